popcount_cfu_arbiter: RTL and testbench

- Shares one combinational 32-bit popcount datapath between NREQ CFU requesters.
- Uses round-robin arbitration and a single-entry registered response stage with per-requester valid/ready handshakes.
- Sits between several CPU-side CFU ports and the popcount datapath.
- Gives a fixed 1-cycle request-to-response latency when no backpressure is applied.

---
 rtl/popcount_cfu_arbiter.sv | 100 ++++++++++
 tb/tb_popcount_cfu_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/popcount_cfu_arbiter.sv
// Round-robin arbiter sharing one 32-bit popcount unit between NREQ CFU ports,
// with a single registered response slot. Define POPCOUNT_ARB_HAMMING_EN for the XOR (Hamming) op.
module popcount_cfu_arbiter #(
    parameter int NREQ            = 4,
    parameter int CFU_FUNC_ID_W   = 1,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    localparam int ID_W           = $clog2(NREQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*CFU_FUNC_ID_W-1:0]    req_func_id,
    input  logic [NREQ*CFU_REQ_DATA_W-1:0]   req_data0,
    input  logic [NREQ*CFU_REQ_DATA_W-1:0]   req_data1,
    output logic [NREQ-1:0]                  resp_valid,
    input  logic [NREQ-1:0]                  resp_ready,
    output logic [CFU_RESP_DATA_W-1:0]       resp_data,
    output logic [ID_W-1:0]                  resp_id
);

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

    logic [ID_W-1:0]           last;
    logic [ID_W-1:0]           grant_idx;
    logic [ID_W-1:0]           scan_idx;
    logic                      grant_found;
    logic                      stage_free;
    logic                      accept;
    logic [NREQ-1:0]           grant_onehot;
    logic [CFU_REQ_DATA_W-1:0] op_data0;
    logic [CFU_REQ_DATA_W-1:0] op_data1;
    logic [CFU_REQ_DATA_W-1:0] op_operand;
    logic [5:0]                op_count;

    // ---- stage 0: arbitration and popcount (combinational) ----
    assign stage_free = !(|resp_valid) || resp_ready[resp_id];

    // Scan starts just after the previous winner, so the last winner gets lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = ID_W'((int'(last) + i) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign grant_onehot = NREQ'(1) << grant_idx;
    assign accept       = grant_found && stage_free;
    assign req_ready    = accept ? grant_onehot : '0;

    assign op_data0 = req_data0[grant_idx*CFU_REQ_DATA_W +: CFU_REQ_DATA_W];
    assign op_data1 = req_data1[grant_idx*CFU_REQ_DATA_W +: CFU_REQ_DATA_W];

`ifdef POPCOUNT_ARB_HAMMING_EN
    logic func_hamming;
    logic unused_func_bits;
    assign func_hamming     = req_func_id[grant_idx*CFU_FUNC_ID_W];
    assign unused_func_bits = ^req_func_id;
    assign op_operand       = func_hamming ? (op_data0 ^ op_data1) : op_data0;
`else
    // Without the Hamming op, operand 1 and the function id have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{op_data1, req_func_id};
    assign op_operand    = op_data0;
`endif

    assign op_count = popcount32(op_operand);

    // ---- stage 1: registered response slot ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            last       <= ID_W'(NREQ - 1);
        end else if (accept) begin
            resp_valid <= grant_onehot;
            resp_data  <= CFU_RESP_DATA_W'(op_count);
            resp_id    <= grant_idx;
            last       <= grant_idx;
        end else if (stage_free) begin
            resp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_popcount_cfu_arbiter.sv
// Directed self-checking bench for popcount_cfu_arbiter (NREQ=4).
module tb_popcount_cfu_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_func_id;
    logic [NREQ*32-1:0] req_data0;
    logic [NREQ*32-1:0] req_data1;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [31:0]       resp_data;
    logic [1:0]        resp_id;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_cfu_arbiter #(
        .NREQ(NREQ), .CFU_FUNC_ID_W(1), .CFU_REQ_DATA_W(32), .CFU_RESP_DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func_id(req_func_id),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request from requester k; response must appear one cycle later.
    task automatic run_single(input int k, input logic [31:0] d0, input logic [31:0] d1,
                              input logic fid, input logic [31:0] exp, input string tag);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << k;
        req_valid          = oh;
        req_func_id        = '0;
        req_func_id[k]     = fid;
        req_data0[k*32 +: 32] = d0;
        req_data1[k*32 +: 32] = d1;
        resp_ready         = '1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_id"}, 32'(resp_id), 32'(k));
        check({tag, "_valid"}, 32'(resp_valid), 32'(oh));
    endtask

    initial begin
        logic [NREQ-1:0] exp_oh;
        logic [31:0]     exp_ham;

        rst         = 1'b1;
        req_valid   = '0;
        req_func_id = '0;
        req_data0   = '0;
        req_data1   = '0;
        resp_ready  = '0;
        tick();
        tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single request from requester 2, then idle
        req_valid      = 4'b0100;
        req_data0[2*32 +: 32] = 32'hF0F0F0F0;
        resp_ready     = '1;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("single_valid", 32'(resp_valid), 32'b0100);
        check("single_id", 32'(resp_id), 32'd2);
        check("single_data", resp_data, 32'd16);
        tick();
        check("single_idle", 32'(resp_valid), 32'd0);

        // Round robin: fresh reset so requester 0 leads
        rst = 1'b1;
        #3;
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) req_data0[k*32 +: 32] = 32'h000000FF;
        req_valid  = '1;
        resp_ready = '1;
        for (int n = 0; n < 8; n++) begin
            exp_oh = NREQ'(1) << (n % NREQ);
            #1;
            check("rr_ready", 32'(req_ready), 32'(exp_oh));
            tick();
            check("rr_id", 32'(resp_id), 32'(n % NREQ));
            check("rr_valid", 32'(resp_valid), 32'(exp_oh));
            check("rr_data", resp_data, 32'd8);
        end
        req_valid = '0;
        tick();
        check("rr_drained", 32'(resp_valid), 32'd0);

        // Backpressure on requester 1 while requester 0 waits
        req_valid = 4'b0010;
        req_data0[1*32 +: 32] = 32'hFFFFFFFF;
        #1;
        check("bp_accept1", 32'(req_ready), 32'b0010);
        tick();
        req_valid  = 4'b0001;
        resp_ready = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("bp_ready_zero", 32'(req_ready), 32'd0);
            check("bp_data_hold", resp_data, 32'd32);
            check("bp_valid_hold", 32'(resp_valid), 32'b0010);
            check("bp_id_hold", 32'(resp_id), 32'd1);
            tick();
        end
        resp_ready = '1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("bp_next_id", 32'(resp_id), 32'd0);
        check("bp_next_valid", 32'(resp_valid), 32'b0001);
        check("bp_next_data", resp_data, 32'd8);
        tick();

        // Boundary values
        run_single(0, 32'h00000000, 32'h0, 1'b0, 32'd0, "bnd_zero");
        run_single(3, 32'h80000000, 32'h0, 1'b0, 32'd1, "bnd_msb");
        run_single(1, 32'hFFFFFFFF, 32'h0, 1'b0, 32'd32, "bnd_all");
        tick();

        // Reset while requester 3 holds an unconsumed response
        req_valid  = 4'b1000;
        req_data0[3*32 +: 32] = 32'h0000000F;
        resp_ready = '0;
        tick();
        req_valid = '0;
        check("mid_pending", 32'(resp_valid), 32'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_clear", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        check("mid_no_resp", 32'(resp_valid), 32'd0);
        req_valid  = '1;
        resp_ready = '1;
        #1;
        check("mid_rr_restart", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("mid_first_id", 32'(resp_id), 32'd0);
        tick();

        // Hamming distance op (popcount of operand 0 alone when the feature is absent)
`ifdef POPCOUNT_ARB_HAMMING_EN
        exp_ham = 32'd4;
`else
        exp_ham = 32'd8;
`endif
        run_single(2, 32'hC0C0C0C0, 32'h80808080, 1'b1, exp_ham, "hamming");
        run_single(0, 32'hC0C0C0C0, 32'h80808080, 1'b0, 32'd8, "func0");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
